// File: rtl/qos_vc_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : qos_vc_router                                                 |
// | Purpose  : Classifies a single write stream into NVC virtual-channel     |
// |            FIFOs by the word's class field and drains them onto one      |
// |            registered output stream with a weighted round-robin arbiter. |
// |            Adds per-VC almost-full flags, programmable weights and       |
// |            sticky drop accounting.                                       |
// | Ports    : clk, reset        - clock, synchronous active-high reset      |
// |            in_wr, in_data    - write strobe and word (class in MSBs)     |
// |            vc_weight         - NVC packed WW-bit weights (0 = disabled)  |
// |            out_pause         - downstream hold, blocks pops              |
// |            out_data/valid/vc - registered popped word and its source VC  |
// |            vc_empty/full/almost_full - per-VC occupancy flags            |
// |            drop_err, drop_cnt - sticky drop flag, saturating drop count  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module qos_vc_router #(
  parameter int BW       = 6,
  parameter int NVC      = 4,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int WW       = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_wr,
  input  logic [BW-1:0]             in_data,
  input  logic [NVC*WW-1:0]         vc_weight,
  input  logic                      out_pause,
  output logic [BW-1:0]             out_data,
  output logic                      out_valid,
  output logic [$clog2(NVC)-1:0]    out_vc,
  output logic [NVC-1:0]            vc_empty,
  output logic [NVC-1:0]            vc_full,
  output logic [NVC-1:0]            vc_almost_full,
  output logic                      drop_err,
  output logic [7:0]                drop_cnt
);

  localparam int VCW = $clog2(NVC);
  localparam int AW  = $clog2(DEPTH);

  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_AF    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   C_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] C_PINC  = AW'(1);
  localparam logic [WW-1:0] C_WONE  = WW'(1);

  logic [BW-1:0]  mem    [NVC][DEPTH];
  logic [AW-1:0]  rd_ptr [NVC];
  logic [AW-1:0]  wr_ptr [NVC];
  logic [AW:0]    count  [NVC];
  logic [WW-1:0]  weight [NVC];

  logic [NVC-1:0] eligible;
  logic [NVC-1:0] wr_en;
  logic [NVC-1:0] rd_en;

  logic [VCW-1:0] cls;
  logic [VCW-1:0] cur;
  logic [VCW-1:0] cur_nxt;
  logic [VCW-1:0] pop_vc;
  logic [VCW-1:0] idx;
  logic [WW-1:0]  credit;
  logic [WW-1:0]  credit_nxt;
  logic           pop;
  logic           found;
  logic           drop;

  assign cls  = in_data[BW-1 -: VCW];
  // Fullness is judged on the registered count, so a same-cycle pop
  // never rescues a write aimed at a full VC.
  assign drop = in_wr & vc_full[cls];

  generate
    for (genvar i = 0; i < NVC; i++) begin : g_vc
      assign weight[i]         = vc_weight[i*WW +: WW];
      assign vc_empty[i]       = (count[i] == '0);
      assign vc_full[i]        = (count[i] == C_DEPTH);
      assign vc_almost_full[i] = (count[i] >= C_AF);
      assign eligible[i]       = !vc_empty[i] && (weight[i] != '0);
      assign wr_en[i]          = in_wr && (cls == VCW'(i)) && !vc_full[i];
      assign rd_en[i]          = pop && (pop_vc == VCW'(i));
    end
  endgenerate

  // Weighted round-robin: keep serving cur while it has credit, otherwise
  // scan forward from cur+1 and end the scan on cur itself (k == NVC wraps
  // to cur because NVC is a power of two). The winner pops this cycle and
  // its credit is reloaded minus the pop just taken.
  always_comb begin
    pop        = 1'b0;
    pop_vc     = cur;
    cur_nxt    = cur;
    credit_nxt = credit;
    found      = 1'b0;
    idx        = cur;
    if (!out_pause) begin
      if (eligible[cur] && (credit != '0)) begin
        pop        = 1'b1;
        credit_nxt = credit - C_WONE;
      end else begin
        for (int k = 1; k <= NVC; k++) begin
          idx = cur + VCW'(k);
          if (!found && eligible[idx]) begin
            found      = 1'b1;
            pop        = 1'b1;
            pop_vc     = idx;
            cur_nxt    = idx;
            credit_nxt = weight[idx] - C_WONE;
          end
        end
      end
    end
  end

  // Storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NVC; i++) begin
      if (wr_en[i]) begin
        mem[i][wr_ptr[i]] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NVC; i++) begin
      if (reset) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end else begin
        if (wr_en[i]) begin
          wr_ptr[i] <= wr_ptr[i] + C_PINC;
        end
        if (rd_en[i]) begin
          rd_ptr[i] <= rd_ptr[i] + C_PINC;
        end
        case ({wr_en[i], rd_en[i]})
          2'b10:   count[i] <= count[i] + C_ONE;
          2'b01:   count[i] <= count[i] - C_ONE;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= '0;
      credit    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_vc    <= '0;
      drop_err  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      cur    <= cur_nxt;
      credit <= credit_nxt;
      if (pop) begin
        out_data  <= mem[pop_vc][rd_ptr[pop_vc]];
        out_vc    <= pop_vc;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        drop_err <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qos_vc_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_qos_vc_router                                              |
// | Purpose  : Directed self-checking bench for qos_vc_router (default       |
// |            parameters: BW=6, NVC=4, DEPTH=8, AF_LEVEL=6, WW=3).          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_qos_vc_router;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_wr;
  logic [5:0]  in_data;
  logic [11:0] vc_weight;
  logic        out_pause;
  logic [5:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_vc;
  logic [3:0]  vc_empty;
  logic [3:0]  vc_full;
  logic [3:0]  vc_almost_full;
  logic        drop_err;
  logic [7:0]  drop_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  qos_vc_router dut (
    .clk            (clk),
    .reset          (reset),
    .in_wr          (in_wr),
    .in_data        (in_data),
    .vc_weight      (vc_weight),
    .out_pause      (out_pause),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_vc         (out_vc),
    .vc_empty       (vc_empty),
    .vc_full        (vc_full),
    .vc_almost_full (vc_almost_full),
    .drop_err       (drop_err),
    .drop_cnt       (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] d);
    in_wr   = 1'b1;
    in_data = d;
    step();
    in_wr   = 1'b0;
  endtask

  initial begin
    int exp_vc [12];
    bit pat [11];
    logic [5:0] n0, n1, nxt;
    int remaining;

    exp_vc = '{0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    pat    = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};

    reset     = 1'b1;
    in_wr     = 1'b0;
    in_data   = '0;
    out_pause = 1'b0;
    vc_weight = {3'd1, 3'd1, 3'd1, 3'd1};
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_empty", vc_empty, 4'hF);
    chk("rst_full", vc_full, 4'h0);
    chk("rst_af", vc_almost_full, 4'h0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_vc", out_vc, 0);
    chk("rst_drop_err", drop_err, 0);
    chk("rst_drop_cnt", drop_cnt, 0);

    // Three class-0 words, two-cycle write-to-output latency
    in_wr = 1'b1; in_data = 6'h01;
    step();
    chk("lat_not_yet", out_valid, 0);
    in_data = 6'h02;
    step();
    chk("w1_valid", out_valid, 1);
    chk("w1_data", out_data, 6'h01);
    chk("w1_vc", out_vc, 0);
    in_data = 6'h03;
    step();
    chk("w2_data", out_data, 6'h02);
    in_wr = 1'b0;
    step();
    chk("w3_data", out_data, 6'h03);
    step();
    chk("w3_done_valid", out_valid, 0);
    chk("vc0_empty", vc_empty[0], 1);

    // Fill VC1, overflow by one, then drain in order
    out_pause = 1'b1;
    for (int n = 0; n < 8; n++) begin
      wr(6'h10 + 6'(n));
      if (n == 4) chk("af1_at5", vc_almost_full[1], 0);
      if (n == 5) chk("af1_at6", vc_almost_full[1], 1);
    end
    chk("full1", vc_full[1], 1);
    chk("no_drop_yet", drop_err, 0);
    wr(6'h1F);
    chk("drop_err", drop_err, 1);
    chk("drop_cnt", drop_cnt, 1);
    chk("full1_hold", vc_full[1], 1);
    out_pause = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      chk("drain1_data", out_data, 6'h10 + 6'(n));
      chk("drain1_vc", out_vc, 1);
    end
    step();
    chk("drain1_end", out_valid, 0);
    chk("vc1_empty", vc_empty[1], 1);

    // Weighted arbitration, weights VC0=3, VC1=1
    out_pause = 1'b1;
    vc_weight = {3'd1, 3'd1, 3'd1, 3'd3};
    for (int n = 0; n < 6; n++) wr(6'h01 + 6'(n));
    for (int n = 0; n < 6; n++) wr(6'h11 + 6'(n));
    out_pause = 1'b0;
    n0 = 6'h01;
    n1 = 6'h11;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("wrr_vc", out_vc, exp_vc[k]);
      chk("wrr_valid", out_valid, 1);
      if (exp_vc[k] == 0) begin
        chk("wrr_data0", out_data, n0);
        n0++;
      end else begin
        chk("wrr_data1", out_data, n1);
        n1++;
      end
    end
    step();
    chk("wrr_end", out_valid, 0);

    // Zero weight disables VC2; only VC3 drains
    out_pause = 1'b1;
    vc_weight = {3'd1, 3'd0, 3'd1, 3'd1};
    for (int n = 0; n < 8; n++) wr(6'h20 + 6'(n));
    for (int n = 0; n < 4; n++) wr(6'h30 + 6'(n));
    out_pause = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("w0_vc", out_vc, 3);
      chk("w0_data", out_data, 6'h30 + 6'(k));
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk("w0_idle", out_valid, 0);
    end
    chk("vc2_full", vc_full[2], 1);
    chk("vc3_empty", vc_empty[3], 1);

    // Reset mid-stream with a write to a full VC active
    out_pause = 1'b1;
    for (int n = 0; n < 4; n++) wr(6'h3A + 6'(n));
    out_pause = 1'b0;
    step();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_data", out_data, 6'h3A);
    reset = 1'b1; in_wr = 1'b1; in_data = 6'h25;
    step();
    reset = 1'b0; in_wr = 1'b0;
    chk("mid_rst_empty", vc_empty, 4'hF);
    chk("mid_rst_full", vc_full, 4'h0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    chk("mid_rst_drop_err", drop_err, 0);
    vc_weight = {3'd1, 3'd1, 3'd1, 3'd1};
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_rst_idle", out_valid, 0);
    end

    // Pause for four cycles mid-stream
    out_pause = 1'b1;
    for (int n = 0; n < 6; n++) wr(6'h0A + 6'(n));
    nxt = 6'h0A;
    remaining = 6;
    for (int k = 0; k < 11; k++) begin
      out_pause = pat[k];
      step();
      if (!pat[k] && remaining > 0) begin
        chk("pause_valid", out_valid, 1);
        chk("pause_data", out_data, nxt);
        nxt++;
        remaining--;
      end else begin
        chk("pause_idle", out_valid, 0);
      end
    end
    out_pause = 1'b0;
    chk("pause_all_out", remaining, 0);
    chk("pause_vc0_empty", vc_empty[0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
